axi_id_remap_cnt_table: RTL and testbench

Counted AXI ID remap table: maps wide incoming transaction IDs onto a small pool of outgoing IDs and tracks multiple outstanding transactions per entry. A transaction whose input ID is already in flight reuses that entry's output ID, which preserves AXI same-ID ordering through the remapper. It sits between the AW/AR acceptance path and the B/R return path of the ID remapper; one instance serves writes and one serves reads.

---
 rtl/axi_id_remap_cnt_table.sv | 110 +++++++++++
 tb/tb_axi_id_remap_cnt_table.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/axi_id_remap_cnt_table.sv
// Counted ID remap table: folds wide AXI IDs onto a small outgoing ID pool, counting outstanding txns per entry.
// Optional simulation checks are enabled with `define AXI_ID_REMAP_ASSERTS_EN.
module axi_id_remap_cnt_table #(
  parameter int InIdWidth    = 4,
  parameter int OutIdWidth   = 2,
  parameter int TableSize    = 4,
  parameter int MaxTxnsPerId = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [InIdWidth-1:0]  push_in_id_i,
  output logic [OutIdWidth-1:0] push_out_id_o,
  output logic                  push_ready_o,
  input  logic                  pop_i,
  input  logic [OutIdWidth-1:0] pop_out_id_i,
  output logic [InIdWidth-1:0]  pop_in_id_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int CntWidth = $clog2(MaxTxnsPerId + 1);
  localparam int IdxW     = (TableSize > 1) ? $clog2(TableSize) : 1;
  localparam logic [CntWidth-1:0]   MaxCnt = CntWidth'(MaxTxnsPerId);
  localparam logic [OutIdWidth:0]   TblLim = (OutIdWidth + 1)'(TableSize);

  logic [TableSize-1:0]                valid_q;
  logic [TableSize-1:0][InIdWidth-1:0] id_q;
  logic [TableSize-1:0][CntWidth-1:0]  cnt_q;

  logic            match_hit;
  logic [IdxW-1:0] match_idx, free_idx, sel_idx, pop_idx;
  logic            pop_in_range, push_fire, pop_fire;

  // Lowest-index match and lowest-index free slot, scanned high to low so the lowest wins.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_idx  = '0;
    for (int i = TableSize - 1; i >= 0; i--) begin
      if (valid_q[i] && (id_q[i] == push_in_id_i)) begin
        match_hit = 1'b1;
        match_idx = IdxW'(i);
      end
      if (!valid_q[i]) free_idx = IdxW'(i);
    end
  end

  assign sel_idx       = match_hit ? match_idx : free_idx;
  assign full_o        = &valid_q;
  assign empty_o       = ~|valid_q;
  assign push_out_id_o = OutIdWidth'(sel_idx);
  // A saturated match blocks the push rather than spilling into a second entry.
  assign push_ready_o  = match_hit ? (cnt_q[match_idx] < MaxCnt) : ~full_o;

  assign pop_idx      = pop_out_id_i[IdxW-1:0];
  assign pop_in_range = ({1'b0, pop_out_id_i} < TblLim);
  assign pop_in_id_o  = pop_in_range ? id_q[pop_idx] : '0;

  assign push_fire = push_i & push_ready_o;
  assign pop_fire  = pop_i & pop_in_range & valid_q[pop_idx];

  for (genvar g = 0; g < TableSize; g++) begin : g_entry
    logic                 v_q;
    logic [InIdWidth-1:0] i_q;
    logic [CntWidth-1:0]  c_q;
    logic                 push_here, pop_here;

    assign push_here = push_fire && (sel_idx == IdxW'(g));
    assign pop_here  = pop_fire && (pop_idx == IdxW'(g));

    // Simultaneous push and pop on one entry cancel, so a cnt=1 entry survives.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        v_q <= 1'b0;
        i_q <= '0;
        c_q <= '0;
      end else if (push_here && !pop_here) begin
        if (v_q) begin
          c_q <= c_q + 1'b1;
        end else begin
          v_q <= 1'b1;
          i_q <= push_in_id_i;
          c_q <= CntWidth'(1);
        end
      end else if (pop_here && !push_here) begin
        c_q <= c_q - 1'b1;
        if (c_q == CntWidth'(1)) v_q <= 1'b0;
      end
    end

    assign valid_q[g] = v_q;
    assign id_q[g]    = i_q;
    assign cnt_q[g]   = c_q;

`ifdef AXI_ID_REMAP_ASSERTS_EN
    a_cnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (c_q <= MaxCnt) && (v_q == (c_q != '0)));
`endif
  end

`ifdef AXI_ID_REMAP_ASSERTS_EN
  a_push_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push_i |-> push_ready_o);
  a_pop_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    pop_i |-> (pop_in_range && valid_q[pop_idx]));
  a_params: assert property (@(posedge clk_i)
    ((2 ** OutIdWidth) >= TableSize) && (MaxTxnsPerId >= 1));
`endif

endmodule

// File: tb/tb_axi_id_remap_cnt_table.sv
// Directed bench for axi_id_remap_cnt_table with hand-computed expectations.
module tb_axi_id_remap_cnt_table;
  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       push_i;
  logic [3:0] push_in_id_i;
  logic [1:0] push_out_id_o;
  logic       push_ready_o;
  logic       pop_i;
  logic [1:0] pop_out_id_i;
  logic [3:0] pop_in_id_o;
  logic       full_o;
  logic       empty_o;

  int n_tests = 0;
  int n_fail  = 0;

  axi_id_remap_cnt_table #(
    .InIdWidth(4), .OutIdWidth(2), .TableSize(4), .MaxTxnsPerId(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .push_i(push_i), .push_in_id_i(push_in_id_i),
    .push_out_id_o(push_out_id_o), .push_ready_o(push_ready_o),
    .pop_i(pop_i), .pop_out_id_i(pop_out_id_i), .pop_in_id_o(pop_in_id_o),
    .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock, landing 1ns after the edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_push(input logic [3:0] id);
    push_i = 1'b1; push_in_id_i = id;
    cyc();
    push_i = 1'b0;
  endtask

  task automatic do_pop(input logic [1:0] oid);
    pop_i = 1'b1; pop_out_id_i = oid;
    cyc();
    pop_i = 1'b0;
  endtask

  // Look up an ID without pushing and check the assigned out_id and readiness.
  task automatic probe(input string tag, input logic [3:0] id,
                       input logic [1:0] exp_oid, input logic exp_rdy);
    push_in_id_i = id;
    #1;
    check({tag, "_oid"}, 32'(push_out_id_o), 32'(exp_oid));
    check({tag, "_rdy"}, 32'(push_ready_o), 32'(exp_rdy));
  endtask

  task automatic probe_pop(input string tag, input logic [1:0] oid, input logic [3:0] exp_id);
    pop_out_id_i = oid;
    #1;
    check(tag, 32'(pop_in_id_o), 32'(exp_id));
  endtask

  initial begin
    rst_ni = 1'b0; push_i = 1'b0; push_in_id_i = 4'h0; pop_i = 1'b0; pop_out_id_i = 2'd0;
    cyc(); cyc();
    // Outputs while reset is still held.
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_empty", 32'(empty_o), 32'd1);
    probe("rst", 4'h0, 2'd0, 1'b1);
    probe_pop("rst_popid", 2'd0, 4'h0);
    rst_ni = 1'b1;
    cyc();

    // Single push then pop.
    probe("t1_push", 4'hA, 2'd0, 1'b1);
    do_push(4'hA);
    check("t1_empty", 32'(empty_o), 32'd0);
    check("t1_full", 32'(full_o), 32'd0);
    probe_pop("t1_popid", 2'd0, 4'hA);
    do_pop(2'd0);
    check("t1_empty_after", 32'(empty_o), 32'd1);

    // Repeated ID shares entry 0; entry frees only after the last pop.
    do_push(4'hA); do_push(4'hA);
    probe("t2_a3", 4'hA, 2'd0, 1'b1);
    do_push(4'hA);
    probe("t2_b", 4'hB, 2'd1, 1'b1);
    do_push(4'hB);
    probe_pop("t2_popid1", 2'd1, 4'hB);
    do_pop(2'd0);
    probe("t2_pop1", 4'hC, 2'd2, 1'b1);
    do_pop(2'd0);
    probe("t2_pop2", 4'hC, 2'd2, 1'b1);
    do_pop(2'd0);
    probe("t2_pop3", 4'hC, 2'd0, 1'b1);
    do_pop(2'd1);
    check("t2_empty", 32'(empty_o), 32'd1);

    // Saturation at MaxTxnsPerId.
    for (int i = 0; i < 8; i++) do_push(4'hC);
    probe("t3_sat", 4'hC, 2'd0, 1'b0);
    probe("t3_other", 4'hD, 2'd1, 1'b1);
    do_push(4'hC);  // refused push must not bump the count
    do_pop(2'd0);
    probe("t3_restored", 4'hC, 2'd0, 1'b1);
    for (int i = 0; i < 7; i++) do_pop(2'd0);
    check("t3_empty", 32'(empty_o), 32'd1);

    // Full table; freed entry not reallocated in the same cycle.
    do_push(4'h1); do_push(4'h2); do_push(4'h3); do_push(4'h4);
    check("t4_full", 32'(full_o), 32'd1);
    probe("t4_new", 4'h5, 2'd0, 1'b0);
    pop_i = 1'b1; pop_out_id_i = 2'd2; push_i = 1'b1; push_in_id_i = 4'h5;
    cyc();
    pop_i = 1'b0; push_i = 1'b0;
    check("t4_full_after_pop", 32'(full_o), 32'd0);
    probe("t4_realloc", 4'h5, 2'd2, 1'b1);
    do_push(4'h5);
    check("t4_full_again", 32'(full_o), 32'd1);
    probe_pop("t4_popid2", 2'd2, 4'h5);
    do_pop(2'd0); do_pop(2'd1); do_pop(2'd2); do_pop(2'd3);
    check("t4_empty", 32'(empty_o), 32'd1);

    // Same-entry push+pop at cnt=1 keeps the entry.
    do_push(4'h6); do_push(4'h7); do_push(4'h8);
    pop_i = 1'b1; pop_out_id_i = 2'd1; push_i = 1'b1; push_in_id_i = 4'h7;
    cyc();
    pop_i = 1'b0; push_i = 1'b0;
    probe("t5_kept", 4'h9, 2'd3, 1'b1);
    probe("t5_match", 4'h7, 2'd1, 1'b1);
    do_pop(2'd1);
    probe("t5_freed", 4'h9, 2'd1, 1'b1);
    // Push and pop on different entries in one cycle.
    pop_i = 1'b1; pop_out_id_i = 2'd0; push_i = 1'b1; push_in_id_i = 4'h9;
    cyc();
    pop_i = 1'b0; push_i = 1'b0;
    probe("t5_split", 4'hF, 2'd0, 1'b1);
    probe_pop("t5_popid1", 2'd1, 4'h9);

    // Mid-operation reset with three entries busy.
    do_push(4'hA);
    check("t6_busy_empty", 32'(empty_o), 32'd0);
    rst_ni = 1'b0; pop_i = 1'b1; pop_out_id_i = 2'd0; push_i = 1'b1; push_in_id_i = 4'hB;
    cyc();
    rst_ni = 1'b1; pop_i = 1'b0; push_i = 1'b0;
    check("t6_empty", 32'(empty_o), 32'd1);
    check("t6_full", 32'(full_o), 32'd0);
    probe_pop("t6_popid", 2'd1, 4'h0);
    do_pop(2'd0);
    check("t6_pop_ignored", 32'(empty_o), 32'd1);
    probe("t6_probe", 4'hA, 2'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
